lsu_mem_responder: RTL and testbench

//  Memory-side responder for the core's load/store path.
//  - Accepts sized load/store requests tagged with RV32 funct3 (f3Ld / f3St encodings).
//  - Performs the access on an internal word-organised data RAM.
//  - Returns sign/zero-extended load data, or an error flag, over a valid/ready response channel.
//  - Sits between the execute stage's LOAD/STORE issue logic and local data storage.

---
 rtl/lsu_pkg.sv | 65 ++++++
 rtl/lsu_mem_responder_if.sv | 25 ++
 rtl/lsu_lane_align.sv | 27 ++
 rtl/lsu_mem_responder.sv | 109 ++++++++++
 tb/tb_lsu_mem_responder.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store types and lane helpers for the memory-side responder.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsuRspState;

  // RV32 load funct3 encodings
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } f3Ld;

  // RV32 store funct3 encodings
  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010
  } f3St;

  // Byte lanes touched by a store of the given size at addr[1:0].
  function automatic logic [3:0] byteEnable(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_SB:   return 4'b0001 << a;
      F3_SH:   return 4'b0011 << {a[1], 1'b0};
      F3_SW:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Pick the addressed lane out of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] loadExtend(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LW:   return word;
      F3_LBU:  return {24'h0, b};
      F3_LHU:  return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  // Halves must be 2-byte aligned, words 4-byte aligned.
  function automatic logic misaligned(input logic we, input logic [2:0] f3, input logic [1:0] a);
    if (we)
      return ((f3 == F3_SH) && a[0]) || ((f3 == F3_SW) && (a != 2'b00));
    else
      return (((f3 == F3_LH) || (f3 == F3_LHU)) && a[0]) || ((f3 == F3_LW) && (a != 2'b00));
  endfunction

  // funct3 values with no meaning for the given direction.
  function automatic logic illegalF3(input logic we, input logic [2:0] f3);
    if (we)
      return f3 >= 3'b011;
    else
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_mem_responder_if.sv
// Request/response channel between the execute-stage LSU and the responder.
interface lsu_mem_responder_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store replicate + byte enables, load extract + extend.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [31:0] o_wword,
  output logic [3:0]  o_be,
  output logic [31:0] o_rdata
);

  // Replicate the right-aligned store data into every lane; byte enables pick the live one.
  always_comb begin
    o_wword = i_wdata;
    case (i_funct3)
      F3_SB:   o_wword = {4{i_wdata[7:0]}};
      F3_SH:   o_wword = {2{i_wdata[15:0]}};
      default: o_wword = i_wdata;
    endcase
  end

  assign o_be    = byteEnable(i_funct3, i_addr_lo);
  assign o_rdata = loadExtend(i_funct3, i_addr_lo, i_rword);

endmodule

// File: rtl/lsu_mem_responder.sv
// Memory-side responder: latches one load/store, performs it on a local RAM,
// and returns extended load data or an error over a valid/ready response.
module lsu_mem_responder
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic            clk,
  input  logic            rst,
  lsu_mem_responder_if.slave io_lsu
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  lsuRspState        r_state, w_next;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_ram [DEPTH_WORDS];

  logic [IDX_W-1:0]  w_idx;
  logic [31:0]       w_rword, w_wword, w_ldata;
  logic [3:0]        w_be;
  logic              w_oor, w_err, w_accept;
  logic              w_req_ready, w_rsp_valid;

  assign w_idx    = r_addr[IDX_W+1:2];
  assign w_rword  = r_ram[w_idx];
  assign w_oor    = |r_addr[ADDR_W-1:IDX_W+2];
  assign w_err    = w_oor | misaligned(r_we, r_f3, r_addr[1:0]) | illegalF3(r_we, r_f3);
  assign w_accept = (r_state == IDLE) && io_lsu.req_valid;

  lsu_lane_align u_align (
    .i_funct3  (r_f3),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rword   (w_rword),
    .o_wword   (w_wword),
    .o_be      (w_be),
    .o_rdata   (w_ldata)
  );

  // State register; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state: one cycle each in IDLE/ACCESS, RESP holds until consumed.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (io_lsu.req_valid) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    if (io_lsu.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state; ready held low while in reset.
  always_comb begin
    w_req_ready = (r_state == IDLE) && !rst;
    w_rsp_valid = (r_state == RESP);
  end

  assign io_lsu.req_ready = w_req_ready;
  assign io_lsu.rsp_valid = w_rsp_valid;
  assign io_lsu.rsp_rdata = r_rdata;
  assign io_lsu.rsp_err   = r_err;

  // Latch the request so the issuer may move on after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= 32'h0;
    end else if (w_accept) begin
      r_we    <= io_lsu.req_we;
      r_f3    <= io_lsu.req_funct3;
      r_addr  <= io_lsu.req_addr;
      r_wdata <= io_lsu.req_wdata;
    end
  end

  // Capture the response at the end of ACCESS; it then stays put through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (r_state == ACCESS) begin
      r_err   <= w_err;
      r_rdata <= (w_err || r_we) ? 32'h0 : w_ldata;
    end
  end

  // Byte-masked RAM write; an async reset forces IDLE, so a reset before this edge cancels it.
  always_ff @(posedge clk) begin
    if ((r_state == ACCESS) && r_we && !w_err) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_ram[w_idx][b*8 +: 8] <= w_wword[b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench for lsu_mem_responder: sized loads/stores, errors, backpressure, reset.
module tb_lsu_mem_responder;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  lsu_mem_responder_if #(.ADDR_W(32)) bus ();

  lsu_mem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_lsu (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction starting in the low clock phase with the DUT idle.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd, output logic e,
                      output int lat);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_wdata  = 32'h5A5A_5A5A;
    @(negedge clk);
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rd = bus.rsp_rdata;
    e  = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;

    rst = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h0);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err",   {31'h0, bus.rsp_err},   32'h0);
    rst = 1'b0;
    #1 chk("post_rst_ready", {31'h0, bus.req_ready}, 32'h1);

    // 1: SW then LW, plus response latency
    xact(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, e, lat);
    chk("sw_lat",   lat,              2);
    chk("sw_err",   {31'h0, e},       32'h0);
    chk("sw_rdata", rd,               32'h0);
    chk("idle_ready", {31'h0, bus.req_ready}, 32'h1);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
    chk("lw_lat",   lat,              2);
    chk("lw_rdata", rd,               32'hDEAD_BEEF);
    chk("lw_err",   {31'h0, e},       32'h0);

    // 2: SB into top lane, signed/unsigned byte loads
    xact(1'b1, 3'b000, 32'h13, 32'h0000_0080, rd, e, lat);
    chk("sb_err",   {31'h0, e}, 32'h0);
    xact(1'b0, 3'b000, 32'h13, 32'h0, rd, e, lat);
    chk("lb_rdata", rd, 32'hFFFF_FF80);
    xact(1'b0, 3'b100, 32'h13, 32'h0, rd, e, lat);
    chk("lbu_rdata", rd, 32'h0000_0080);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
    chk("lw_after_sb", rd, 32'h80AD_BEEF);
    xact(1'b0, 3'b000, 32'h11, 32'h0, rd, e, lat);
    chk("lb_lane1", rd, 32'hFFFF_FFBE);

    // 3: misalignment
    xact(1'b0, 3'b001, 32'h11, 32'h0, rd, e, lat);
    chk("lh_mis_err",   {31'h0, e}, 32'h1);
    chk("lh_mis_rdata", rd,         32'h0);
    xact(1'b1, 3'b010, 32'h12, 32'h1234_5678, rd, e, lat);
    chk("sw_mis_err",   {31'h0, e}, 32'h1);
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
    chk("lw_after_mis", rd, 32'h80AD_BEEF);
    chk("lw_after_mis_err", {31'h0, e}, 32'h0);

    // 4: illegal funct3, out of range, legal half store
    xact(1'b0, 3'b011, 32'h0, 32'h0, rd, e, lat);
    chk("ld_f3_011_err", {31'h0, e}, 32'h1);
    chk("ld_f3_011_rdata", rd, 32'h0);
    xact(1'b1, 3'b101, 32'h0, 32'h0, rd, e, lat);
    chk("st_f3_101_err", {31'h0, e}, 32'h1);
    xact(1'b0, 3'b010, 32'h1000, 32'h0, rd, e, lat);
    chk("lw_oor_err", {31'h0, e}, 32'h1);
    chk("lw_oor_rdata", rd, 32'h0);
    xact(1'b1, 3'b001, 32'h2, 32'h0000_BEEF, rd, e, lat);
    chk("sh_err", {31'h0, e}, 32'h0);
    xact(1'b0, 3'b101, 32'h2, 32'h0, rd, e, lat);
    chk("lhu_rdata", rd, 32'h0000_BEEF);
    xact(1'b0, 3'b001, 32'h2, 32'h0, rd, e, lat);
    chk("lh_rdata", rd, 32'hFFFF_BEEF);

    // 5: backpressure; a competing store held on req_valid must be ignored
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    @(posedge clk);
    #1;
    bus.req_we = 1'b1; bus.req_wdata = 32'h0BAD_0BAD;
    lat = 0;
    @(negedge clk);
    while (!bus.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_lat", lat, 1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {31'h0, bus.rsp_valid}, 32'h1);
      chk("bp_rdata", bus.rsp_rdata, 32'h80AD_BEEF);
      chk("bp_err",   {31'h0, bus.rsp_err}, 32'h0);
      chk("bp_ready", {31'h0, bus.req_ready}, 32'h0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_retired",   {31'h0, bus.rsp_valid}, 32'h0);
    chk("bp_ready_next", {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid = 1'b0;
    xact(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
    chk("bp_no_write", rd, 32'h80AD_BEEF);

    // 6: reset during ACCESS of a store
    xact(1'b1, 3'b010, 32'h20, 32'h1122_3344, rd, e, lat);
    chk("pre_sw_err", {31'h0, e}, 32'h0);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h20; bus.req_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_mid_ready", {31'h0, bus.req_ready}, 32'h0);
    @(negedge clk);
    chk("rst_hold_valid", {31'h0, bus.rsp_valid}, 32'h0);
    rst = 1'b0;
    #1;
    chk("rst_rel_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_rel_valid", {31'h0, bus.rsp_valid}, 32'h0);
    @(negedge clk);
    chk("rst_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
    xact(1'b0, 3'b010, 32'h20, 32'h0, rd, e, lat);
    chk("rst_prior_data", rd, 32'h1122_3344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
